// File: rtl/dom_and_sched.sv
// Scheduler that time-shares one masked (DOM-dep) AND gadget between two
// requesters. It arbitrates round-robin, pairs each issue with exactly one
// randomness handshake, and registers operands and masks into the gadget.
// A {valid, owner} tag pipeline routes each gadget product back to the
// requester that issued it.
module dom_and_sched #(
    parameter int D         = 1,  // masking order
    parameter int BIT_WIDTH = 1,  // parallel one-bit AND lanes
    parameter int LAT       = 1,  // gadget latency, legal range 1..4
    localparam int N        = D + 1,
    localparam int L        = ((D + 1) * D) / 2,
    localparam int NW       = N * BIT_WIDTH,
    localparam int LW       = L * BIT_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    input  logic          req1_valid,
    output logic          req0_ready,
    output logic          req1_ready,
    input  logic [NW-1:0] req0_a,
    input  logic [NW-1:0] req0_b,
    input  logic [NW-1:0] req1_a,
    input  logic [NW-1:0] req1_b,
    input  logic          rnd_valid,
    output logic          rnd_ready,
    input  logic [NW-1:0] rnd_r1,
    input  logic [LW-1:0] rnd_r2,
    output logic [NW-1:0] gad_a,
    output logic [NW-1:0] gad_b,
    output logic [NW-1:0] gad_r1,
    output logic [LW-1:0] gad_r2,
    input  logic [NW-1:0] gad_c,
    output logic          rsp0_valid,
    output logic          rsp1_valid,
    output logic [NW-1:0] rsp0_c,
    output logic [NW-1:0] rsp1_c,
    output logic          busy
);

    logic          prio_q, prio_d;
    logic          grant0, grant1;
    logic          issue, issue_own;

    logic [NW-1:0] gad_a_q, gad_a_d;
    logic [NW-1:0] gad_b_q, gad_b_d;
    logic [NW-1:0] gad_r1_q, gad_r1_d;
    logic [LW-1:0] gad_r2_q, gad_r2_d;

    logic [LAT:0]  tag_v_q, tag_v_d;
    logic [LAT:0]  tag_own_q, tag_own_d;

    logic          rsp0_valid_q, rsp0_valid_d;
    logic          rsp1_valid_q, rsp1_valid_d;
    logic [NW-1:0] rsp0_c_q, rsp0_c_d;
    logic [NW-1:0] rsp1_c_q, rsp1_c_d;

    // Round-robin grant; ready is gated by reset so nothing is accepted while held.
    always_comb begin
        grant0     = req0_valid && (!prio_q || !req1_valid);
        grant1     = req1_valid && ( prio_q || !req0_valid);
        req0_ready = rst && rnd_valid && grant0;
        req1_ready = rst && rnd_valid && grant1;
        issue      = req0_ready || req1_ready;
        issue_own  = req1_ready;
        rnd_ready  = issue;
        prio_d     = issue ? !issue_own : prio_q;
    end

    // Gadget inputs: operands of the granted requester plus masks, zero when idle.
    always_comb begin
        gad_a_d  = '0;
        gad_b_d  = '0;
        gad_r1_d = '0;
        gad_r2_d = '0;
        if (issue) begin
            gad_a_d  = issue_own ? req1_a : req0_a;
            gad_b_d  = issue_own ? req1_b : req0_b;
            gad_r1_d = rnd_r1;
            gad_r2_d = rnd_r2;
        end
    end

    // Tag shift register; stage LAT-1 marks the cycle gad_c holds the product.
    always_comb begin
        tag_v_d   = {tag_v_q[LAT-1:0], issue};
        tag_own_d = {tag_own_q[LAT-1:0], issue_own};
    end

    // Capture gad_c for the owning requester only; the other result holds.
    always_comb begin
        rsp0_valid_d = tag_v_q[LAT-1] && !tag_own_q[LAT-1];
        rsp1_valid_d = tag_v_q[LAT-1] &&  tag_own_q[LAT-1];
        rsp0_c_d     = rsp0_valid_d ? gad_c : rsp0_c_q;
        rsp1_c_d     = rsp1_valid_d ? gad_c : rsp1_c_q;
    end

    // State registers; reset discards everything in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prio_q       <= 1'b0;
            gad_a_q      <= '0;
            gad_b_q      <= '0;
            gad_r1_q     <= '0;
            gad_r2_q     <= '0;
            tag_v_q      <= '0;
            tag_own_q    <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_c_q     <= '0;
            rsp1_c_q     <= '0;
        end else begin
            prio_q       <= prio_d;
            gad_a_q      <= gad_a_d;
            gad_b_q      <= gad_b_d;
            gad_r1_q     <= gad_r1_d;
            gad_r2_q     <= gad_r2_d;
            tag_v_q      <= tag_v_d;
            tag_own_q    <= tag_own_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp0_c_q     <= rsp0_c_d;
            rsp1_c_q     <= rsp1_c_d;
        end
    end

    assign gad_a      = gad_a_q;
    assign gad_b      = gad_b_q;
    assign gad_r1     = gad_r1_q;
    assign gad_r2     = gad_r2_q;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp0_c     = rsp0_c_q;
    assign rsp1_c     = rsp1_c_q;
    assign busy       = |tag_v_q;

endmodule

// File: doc/dom_and_sched.md
DOM_AND_SCHED -- requirements
Module: dom_and_sched

Interface
REQ-001 D, default 1, masking order; share count N=D+1, randomness bits per lane L=((D+1)*D)/2.
REQ-002 BIT_WIDTH, default 1, number of parallel one-bit DOM-dep AND lanes in the shared gadget.
REQ-003 LAT, default 1, fixed cycle latency of the attached gadget from registered inputs to port_c; legal range 1..4.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 req0_valid / req1_valid  in  1 each  requester operand valid.
REQ-007 req0_ready / req1_ready  out  1 each  operand accepted this cycle.
REQ-008 req0_a, req0_b, req1_a, req1_b  in  N*BIT_WIDTH each  shared operands; lane i occupies bits [i*N +: N].
REQ-009 rnd_valid  in  1  fresh randomness available.
REQ-010 rnd_ready  out  1  randomness consumed this cycle.
REQ-011 rnd_r1  in  N*BIT_WIDTH;  rnd_r2  in  L*BIT_WIDTH  fresh masks.
REQ-012 gad_a, gad_b, gad_r1  out  N*BIT_WIDTH;  gad_r2  out  L*BIT_WIDTH  registered gadget inputs.
REQ-013 gad_c  in  N*BIT_WIDTH  gadget shared product.
REQ-014 rsp0_valid / rsp1_valid  out  1 each;  rsp0_c / rsp1_c  out  N*BIT_WIDTH  registered result to owning requester.
REQ-015 busy  out  1  any operation in flight.

Function
REQ-016 Issue SHALL occur in a cycle only when rnd_valid=1 and at least one req valid; exactly one requester granted per issue.
REQ-017 Arbitration SHALL be round-robin: pointer prio selects preferred requester; other requester granted only if preferred not valid.
REQ-018 After an issue to requester k, prio SHALL become 1-k; prio unchanged in cycles without issue.
REQ-019 reqk_ready SHALL be combinational: rnd_valid AND grant_k; rnd_ready SHALL equal (req0_ready OR req1_ready).
REQ-020 No combinational path from req*/rnd_* data to gad_*; on issue, operands and masks SHALL be registered into gad_* at the next edge.
REQ-021 In cycles with no issue, gad_a, gad_b, gad_r1, gad_r2 SHALL be loaded with all-zero at the next edge (no stale shares presented).
REQ-022 Randomness SHALL never be reused: each issue consumes exactly one rnd handshake.
REQ-023 Tag pipeline: a LAT+1 deep shift register of {valid, owner} SHALL track each issue, stage 0 loaded at issue edge alongside gad_*.
REQ-024 Latency: issue accepted in cycle t -> gad_* valid in t+1 -> gad_c sampled at end of t+LAT -> rspk_valid=1 with rspk_c=gad_c in cycle t+1+LAT, single-cycle pulse.
REQ-025 Throughput: one issue per cycle sustained; back-to-back issues SHALL produce back-to-back responses in issue order.
REQ-026 rspj_c for non-owning requester SHALL be held at previous value; rspk_c updates only when rspk_valid asserts.
REQ-027 Responses have no backpressure; requesters SHALL accept every rsp*_valid pulse.
REQ-028 busy SHALL be 1 when any tag stage valid, else 0; busy does not block issue.
REQ-029 Simultaneous req0_valid and req1_valid with rnd_valid=0: no grant, both ready=0, prio unchanged.

Reset
REQ-030 On rst=0, asynchronously: prio=0, all tag stages invalid, gad_* zero, rsp*_valid=0, rsp*_c zero, busy=0.
REQ-031 Reset mid-operation SHALL discard in-flight operations; no response emitted for them after reset release.
REQ-032 While rst=0, req*_ready and rnd_ready SHALL be 0.

Verification
REQ-033 D=1,BIT_WIDTH=1,LAT=1: req0 a=2'b01,b=2'b11 (unmasked 1,0), rnd_valid=1 at cycle 0 -> req0_ready=1, rnd_ready=1, rsp0_valid=1 at cycle 2, XOR of rsp0_c shares = 0.
REQ-034 Both valid continuously for 4 cycles, rnd_valid=1 -> grants 0,1,0,1; responses alternate rsp0,rsp1,rsp0,rsp1 at cycles 2..5.
REQ-035 Both valid, rnd_valid=0 for 3 cycles then 1 -> no ready for 3 cycles, req0 granted in cycle 3, gad_* zero in cycles 1..3.
REQ-036 Only req1 valid with prio=0 -> req1 granted, prio becomes 0; subsequent req0-only issue granted immediately.
REQ-037 Issue at cycle 0, rst=0 at cycle 1 for one cycle -> no rsp*_valid afterwards, busy=0, gad_* zero.
REQ-038 Random BIT_WIDTH=4, D=2, LAT=3 stream of 200 issues vs. reference AND model -> XOR-recombined rsp*_c equals a&b per lane, correct owner, exact t+1+LAT timing.
